// File: rtl/arbiter_rr_burst.sv
// Round-robin burst arbiter: shares one memory command/data port among NUM_CORES cores.
// Optional stall timeout abort enabled by defining ARB_TIMEOUT_EN.
module arbiter_rr_burst #(
  parameter int unsigned MAIN_MEM_ADDR_WIDTH = 32,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned BURST_WIDTH = 6,
  parameter logic [MAIN_MEM_ADDR_WIDTH-1:0] WR_OFFSET = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           w_clock,
  input  logic                           w_reset,
  input  logic [NUM_CORES-1:0]           w_req,
  input  logic                           w_cfg_we,
  input  logic [$clog2(NUM_CORES)-1:0]   w_cfg_core,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_cfg_addr,
  input  logic [BURST_WIDTH-1:0]         w_cfg_burst,
  output logic                           w_cmd_valid,
  input  logic                           w_cmd_ready,
  output logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
  output logic                           w_rw,
  output logic [BURST_WIDTH-1:0]         w_burst,
  input  logic                           w_beat,
  output logic [NUM_CORES-1:0]           w_grant,
  output logic                           w_done,
  output logic                           w_error
);

  localparam int unsigned CoreW = $clog2(NUM_CORES);

  typedef enum logic [2:0] {StIdle, StArb, StCmd, StBeat, StDone} state_t;

  state_t                         state;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] base_tbl  [NUM_CORES];
  logic [BURST_WIDTH-1:0]         burst_tbl [NUM_CORES];
  logic [NUM_CORES-1:0]           phase;
  logic [CoreW-1:0]               ptr;
  logic [CoreW-1:0]               sel;
  logic [BURST_WIDTH-1:0]         beat_cnt;

  logic [CoreW-1:0]               pick;
  logic                           pick_vld;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] pick_addr;

  // Search starts just after the last granted core, so it becomes lowest priority.
  always_comb begin
    int unsigned idx;
    logic [CoreW-1:0] idx_c;
    pick     = ptr;
    pick_vld = 1'b0;
    idx      = 0;
    idx_c    = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      idx   = (32'(ptr) + i) % NUM_CORES;
      idx_c = CoreW'(idx);
      if (!pick_vld && w_req[idx_c]) begin
        pick     = idx_c;
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_addr = base_tbl[pick] + (phase[pick] ? WR_OFFSET : '0);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);

  logic [StallW-1:0] stall_cnt;
  logic              timed_out;
  logic              stalled;

  always_comb begin
    stalled = ((state == StCmd) && !w_cmd_ready) || ((state == StBeat) && !w_beat);
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign w_error = 1'b0;
`endif

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      state       <= StIdle;
      ptr         <= CoreW'(NUM_CORES - 1);
      sel         <= '0;
      phase       <= '0;
      beat_cnt    <= '0;
      w_cmd_valid <= 1'b0;
      w_addr      <= '0;
      w_rw        <= 1'b0;
      w_burst     <= '0;
      w_grant     <= '0;
      w_done      <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        base_tbl[i]  <= '0;
        burst_tbl[i] <= '0;
      end
`ifdef ARB_TIMEOUT_EN
      stall_cnt <= '0;
      timed_out <= 1'b0;
      w_error   <= 1'b0;
`endif
    end else begin
      // ARB reads the table registered before this edge, so a same-cycle write is seen next ARB.
      if (w_cfg_we && (32'(w_cfg_core) < NUM_CORES)) begin
        base_tbl[w_cfg_core]  <= w_cfg_addr;
        burst_tbl[w_cfg_core] <= w_cfg_burst;
      end

      unique case (state)
        StIdle: begin
          if (|w_req) state <= StArb;
        end
        StArb: begin
          if (pick_vld) begin
            sel         <= pick;
            w_rw        <= phase[pick];
            w_addr      <= pick_addr;
            w_burst     <= burst_tbl[pick];
            w_grant     <= NUM_CORES'(1) << pick;
            w_cmd_valid <= 1'b1;
            state       <= StCmd;
`ifdef ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            timed_out   <= 1'b0;
`endif
          end else begin
            state <= StIdle;
          end
        end
        StCmd: begin
          if (w_cmd_ready) begin
            w_cmd_valid <= 1'b0;
            beat_cnt    <= '0;
            if (w_burst == '0) begin
              w_done <= 1'b1;
              state  <= StDone;
            end else begin
              state <= StBeat;
            end
          end
        end
        StBeat: begin
          if (w_beat) begin
            if (beat_cnt == w_burst - 1'b1) begin
              w_done <= 1'b1;
              state  <= StDone;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          w_done  <= 1'b0;
          w_grant <= '0;
          ptr     <= sel;
          state   <= StIdle;
`ifdef ARB_TIMEOUT_EN
          // An aborted transaction is retried with the same direction.
          if (!timed_out) phase[sel] <= ~phase[sel];
`else
          phase[sel] <= ~phase[sel];
`endif
        end
        default: state <= StIdle;
      endcase

`ifdef ARB_TIMEOUT_EN
      if (stalled) begin
        if (32'(stall_cnt) == TIMEOUT_CYCLES - 1) begin
          w_cmd_valid <= 1'b0;
          w_done      <= 1'b1;
          w_error     <= 1'b1;
          timed_out   <= 1'b1;
          state       <= StDone;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else if ((state == StCmd) || (state == StBeat)) begin
        stall_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Self-checking bench for arbiter_rr_burst: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_arbiter_rr_burst;

  localparam int unsigned AW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned BW = 6;
  localparam logic [AW-1:0] WOFF = 32'h0000_1000;
  localparam int unsigned TO = 8;

  logic          w_clock = 1'b0;
  logic          w_reset;
  logic [NC-1:0] w_req;
  logic          w_cfg_we;
  logic [1:0]    w_cfg_core;
  logic [AW-1:0] w_cfg_addr;
  logic [BW-1:0] w_cfg_burst;
  logic          w_cmd_valid;
  logic          w_cmd_ready;
  logic [AW-1:0] w_addr;
  logic          w_rw;
  logic [BW-1:0] w_burst;
  logic          w_beat;
  logic [NC-1:0] w_grant;
  logic          w_done;
  logic          w_error;

  arbiter_rr_burst #(
    .MAIN_MEM_ADDR_WIDTH(AW),
    .NUM_CORES(NC),
    .BURST_WIDTH(BW),
    .WR_OFFSET(WOFF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .w_clock(w_clock),
    .w_reset(w_reset),
    .w_req(w_req),
    .w_cfg_we(w_cfg_we),
    .w_cfg_core(w_cfg_core),
    .w_cfg_addr(w_cfg_addr),
    .w_cfg_burst(w_cfg_burst),
    .w_cmd_valid(w_cmd_valid),
    .w_cmd_ready(w_cmd_ready),
    .w_addr(w_addr),
    .w_rw(w_rw),
    .w_burst(w_burst),
    .w_beat(w_beat),
    .w_grant(w_grant),
    .w_done(w_done),
    .w_error(w_error)
  );

  initial forever #5 w_clock = ~w_clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one in-flight transaction described by its progress, not by FSM states.
  logic [AW-1:0] m_base [NC];
  logic [BW-1:0] m_blen [NC];
  bit            m_phase [NC];
  int            m_ptr;
  bit            m_pending;   // a request was seen while idle; arbitration happens next edge
  bit            m_busy;      // a core holds the grant
  bit            m_cmd;       // command not yet accepted
  bit            m_end;       // completion cycle
  bit            m_tout;
  bit            m_err;
  int            m_core;
  int            m_left;
  int            m_stall;
  bit            m_rw;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_bl;

  task automatic model_step();
    bit stalled;
    stalled = 1'b0;
    if (w_reset) begin
      for (int i = 0; i < NC; i++) begin
        m_base[i] = '0; m_blen[i] = '0; m_phase[i] = 1'b0;
      end
      m_ptr = NC - 1; m_pending = 0; m_busy = 0; m_cmd = 0; m_end = 0; m_tout = 0; m_err = 0;
      m_stall = 0;
    end else begin
      if (m_end) begin
        m_end = 0;
        m_busy = 0;
        if (!m_tout) m_phase[m_core] = !m_phase[m_core];
        m_ptr = m_core;
      end else if (m_busy) begin
        if (m_cmd) begin
          if (w_cmd_ready) begin
            m_cmd = 0; m_stall = 0; m_left = int'(m_bl);
            if (m_bl == 0) m_end = 1;
          end else stalled = 1;
        end else begin
          if (w_beat) begin
            m_left--; m_stall = 0;
            if (m_left == 0) m_end = 1;
          end else stalled = 1;
        end
        if (stalled) m_stall++;
`ifdef ARB_TIMEOUT_EN
        if (stalled && m_stall == TO) begin
          m_end = 1; m_tout = 1; m_err = 1; m_cmd = 0;
        end
`endif
      end else if (m_pending) begin
        m_pending = 0;
        for (int i = 1; i <= NC; i++) begin
          int c;
          c = (m_ptr + i) % NC;
          if (w_req[c]) begin
            m_busy = 1; m_cmd = 1; m_tout = 0; m_stall = 0; m_core = c;
            m_rw = m_phase[c];
            m_addr = m_base[c] + (m_rw ? WOFF : 32'h0);
            m_bl = m_blen[c];
            break;
          end
        end
      end else if (w_req != 0) begin
        m_pending = 1;
      end
      if (w_cfg_we) begin
        m_base[w_cfg_core] = w_cfg_addr;
        m_blen[w_cfg_core] = w_cfg_burst;
      end
    end
  endtask

  initial forever begin
    @(posedge w_clock);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge w_clock);
    if (chk_en) begin
      logic [NC-1:0] eg;
      eg = m_busy ? (NC'(1) << m_core) : '0;
      cmp("grant", 64'(w_grant), 64'(eg));
      cmp("cmd_valid", 64'(w_cmd_valid), 64'(m_busy && m_cmd));
      cmp("done", 64'(w_done), 64'(m_end));
      cmp("error", 64'(w_error), 64'(m_err));
      if (m_busy && m_cmd) begin
        cmp("addr", 64'(w_addr), 64'(m_addr));
        cmp("rw", 64'(w_rw), 64'(m_rw));
        cmp("burst", 64'(w_burst), 64'(m_bl));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge w_clock);
  endtask

  task automatic cfg(input int core, input logic [AW-1:0] addr, input logic [BW-1:0] bl);
    w_cfg_we = 1'b1; w_cfg_core = 2'(core); w_cfg_addr = addr; w_cfg_burst = bl;
    tick();
    w_cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    w_reset = 1'b1;
    tick();
    tick();
    w_reset = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!w_cmd_valid && n < 40) begin
      tick();
      n++;
    end
    cmp(nm, 64'(w_cmd_valid), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!w_done && n < 200) begin
      tick();
      n++;
    end
    cmp(nm, 64'(w_done), 64'd1);
    tick();
  endtask

  logic [NC-1:0] exp_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  bit            exp_rw  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    logic [NC-1:0] got_gnt [8];
    bit            got_rw  [8];
    int            ngot;
    bit            prev_v;

    w_reset = 1'b1; w_req = '0; w_cfg_we = 1'b0; w_cfg_core = '0; w_cfg_addr = '0;
    w_cfg_burst = '0; w_cmd_ready = 1'b0; w_beat = 1'b0;
    tick();
    tick();
    w_reset = 1'b0;
    chk_en = 1'b1;
    tick();
    cmp("rst_grant", 64'(w_grant), 64'd0);
    cmp("rst_valid", 64'(w_cmd_valid), 64'd0);
    cmp("rst_done", 64'(w_done), 64'd0);
    cmp("rst_error", 64'(w_error), 64'd0);

    // Single core0 transaction, then its write-back.
    w_cmd_ready = 1'b1; w_beat = 1'b1;
    cfg(0, 32'h100, 6'd4);
    w_req = 4'b0001;
    tick();
    cmp("lat1_grant", 64'(w_grant), 64'd0);
    tick();
    cmp("lat2_grant", 64'(w_grant), 64'b0001);
    cmp("t1_addr", 64'(w_addr), 64'h100);
    cmp("t1_rw", 64'(w_rw), 64'd0);
    cmp("t1_burst", 64'(w_burst), 64'd4);
    w_req = 4'b0000;
    repeat (5) tick();
    cmp("t1_done", 64'(w_done), 64'd1);
    cmp("t1_done_grant", 64'(w_grant), 64'b0001);
    tick();
    cmp("t1_done_end", 64'(w_done), 64'd0);
    cmp("t1_grant_end", 64'(w_grant), 64'd0);
    w_req = 4'b0001;
    tick();
    tick();
    cmp("t2_addr", 64'(w_addr), 64'h1100);
    cmp("t2_rw", 64'(w_rw), 64'd1);
    w_req = 4'b0000;
    wait_done("t2_wait_done");

    // All cores requesting: rotation order and per-core direction toggling.
    do_reset();
    for (int i = 0; i < NC; i++) cfg(i, 32'(i * 32'h40), 6'd2);
    w_req = 4'b1111;
    ngot = 0;
    prev_v = 1'b0;
    for (int n = 0; n < 200 && ngot < 8; n++) begin
      tick();
      if (w_cmd_valid && !prev_v) begin
        got_gnt[ngot] = w_grant;
        got_rw[ngot] = w_rw;
        ngot++;
      end
      prev_v = w_cmd_valid;
    end
    w_req = 4'b0000;
    cmp("rr_count", 64'(ngot), 64'd8);
    for (int i = 0; i < 8; i++) begin
      cmp($sformatf("rr_grant%0d", i), 64'(got_gnt[i]), 64'(exp_gnt[i]));
      cmp($sformatf("rr_rw%0d", i), 64'(got_rw[i]), 64'(exp_rw[i]));
    end
    repeat (20) tick();

    // Zero-length burst completes right after command acceptance.
    cfg(2, 32'h300, 6'd0);
    w_req = 4'b0100;
    wait_valid("b0_wait_valid");
    w_req = 4'b0000;
    tick();
    cmp("b0_done", 64'(w_done), 64'd1);
    cmp("b0_valid", 64'(w_cmd_valid), 64'd0);
    cmp("b0_grant", 64'(w_grant), 64'b0100);
    tick();
    cmp("b0_done_end", 64'(w_done), 64'd0);
    repeat (3) tick();

    // Command backpressure: stable command, beats during CMD ignored.
    cfg(1, 32'h2000, 6'd3);
    w_cmd_ready = 1'b0; w_beat = 1'b1;
    w_req = 4'b0010;
    wait_valid("bp_wait_valid");
    w_req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cmp("bp_valid", 64'(w_cmd_valid), 64'd1);
      cmp("bp_addr", 64'(w_addr), 64'h2000);
      cmp("bp_burst", 64'(w_burst), 64'd3);
      tick();
    end
    w_cmd_ready = 1'b1;
    repeat (4) tick();
    cmp("bp_done", 64'(w_done), 64'd1);
    repeat (3) tick();

    // Reset mid-burst aborts and clears core0 direction.
    cfg(0, 32'h400, 6'd4);
    w_req = 4'b0001;
    wait_valid("mr_wait_valid1");
    cmp("mr_rw1", 64'(w_rw), 64'd0);
    w_req = 4'b0000;
    wait_done("mr_wait_done1");
    w_req = 4'b0001;
    wait_valid("mr_wait_valid2");
    cmp("mr_rw2", 64'(w_rw), 64'd1);
    cmp("mr_addr2", 64'(w_addr), 64'h1400);
    w_req = 4'b0000;
    repeat (3) tick();
    w_reset = 1'b1;
    tick();
    cmp("mr_grant", 64'(w_grant), 64'd0);
    cmp("mr_valid", 64'(w_cmd_valid), 64'd0);
    cmp("mr_done", 64'(w_done), 64'd0);
    w_reset = 1'b0;
    tick();
    cfg(0, 32'h500, 6'd4);
    w_req = 4'b0001;
    wait_valid("mr_wait_valid3");
    cmp("mr_rw3", 64'(w_rw), 64'd0);
    cmp("mr_addr3", 64'(w_addr), 64'h500);
    w_req = 4'b0000;
    wait_done("mr_wait_done3");

`ifdef ARB_TIMEOUT_EN
    // Stuck beats: abort after TO stalled cycles, retry keeps direction.
    cfg(3, 32'h600, 6'd4);
    w_beat = 1'b0;
    w_req = 4'b1000;
    wait_valid("to_wait_valid");
    cmp("to_rw1", 64'(w_rw), 64'd0);
    repeat (TO + 1) tick();
    cmp("to_done", 64'(w_done), 64'd1);
    cmp("to_error", 64'(w_error), 64'd1);
    w_beat = 1'b1;
    wait_valid("to_wait_retry");
    cmp("to_rw_retry", 64'(w_rw), 64'd0);
    cmp("to_addr_retry", 64'(w_addr), 64'h600);
    w_req = 4'b0000;
    wait_done("to_wait_done");
`endif

    // Randomized traffic, config writes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 4) == 0) w_req = 4'($urandom_range(0, 15));
      w_cmd_ready = ($urandom % 4) != 0;
      w_beat = ($urandom % 4) != 0;
      w_cfg_we = ($urandom % 8) == 0;
      w_cfg_core = 2'($urandom_range(0, NC - 1));
      w_cfg_addr = (($urandom % 4) == 0) ? (32'hFFFF_F000 | 32'($urandom % 32'h1000)) : $urandom;
      w_cfg_burst = 6'($urandom_range(0, 5));
      w_reset = ($urandom % 500) == 0;
      tick();
    end
    w_reset = 1'b0; w_cfg_we = 1'b0; w_req = '0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
